fp8_mul_arbiter: RTL

FP8_MUL_ARBITER -- requirements
Module: fp8_mul_arbiter

---
 rtl/fp8_pkg.sv | 19 +
 rtl/fp8_mul_core.sv | 57 +++++
 rtl/fp8_mul_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fp8_pkg.sv
// FP8 (1-4-3, bias 7) field widths, special-value constants and the field struct
// shared by the multiplier core and the arbiter.
package fp8_pkg;

  localparam int unsigned FP8_W      = 8;
  localparam int unsigned FP8_EXP_W  = 4;
  localparam int unsigned FP8_MANT_W = 3;
  localparam int unsigned FP8_BIAS   = 7;

  localparam logic [FP8_W-1:0]     FP8_QNAN    = 8'h7F;
  localparam logic [FP8_EXP_W-1:0] FP8_INF_EXP = 4'hF;

  typedef struct packed {
    logic                  sign;
    logic [FP8_EXP_W-1:0]  exp;
    logic [FP8_MANT_W-1:0] mant;
  } fp8_t;

endpackage

// File: rtl/fp8_mul_core.sv
// Combinational FP8 multiplier: truncating significand product with one-step
// normalisation, then NaN > inf > zero special-case override.
module fp8_mul_core
  import fp8_pkg::*;
(
  input  logic [FP8_W-1:0] a_i,
  input  logic [FP8_W-1:0] b_i,
  output logic [FP8_W-1:0] product_c
);

  localparam int unsigned SIG_W  = FP8_MANT_W + 1;
  localparam int unsigned PROD_W = 2 * SIG_W;
  localparam logic [FP8_EXP_W-1:0] EXP_ADJ = FP8_EXP_W'((1 << FP8_EXP_W) - FP8_BIAS);

  fp8_t                  a, b;
  logic                  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic                  sign;
  logic [SIG_W-1:0]      sig_a, sig_b;
  logic [PROD_W-1:0]     sig_p;
  logic [FP8_EXP_W-1:0]  exp_sum, exp_n;
  logic [FP8_MANT_W-1:0] mant_n;
  logic                  unused_lsbs;

  assign a = a_i;
  assign b = b_i;

  assign a_nan  = (a.exp == FP8_INF_EXP) && (a.mant != '0);
  assign b_nan  = (b.exp == FP8_INF_EXP) && (b.mant != '0);
  assign a_inf  = (a.exp == FP8_INF_EXP) && (a.mant == '0);
  assign b_inf  = (b.exp == FP8_INF_EXP) && (b.mant == '0);
  assign a_zero = (a.exp == '0);
  assign b_zero = (b.exp == '0);

  assign sign  = a.sign ^ b.sign;
  assign sig_a = {1'b1, a.mant};
  assign sig_b = {1'b1, b.mant};
  assign sig_p = PROD_W'(sig_a) * PROD_W'(sig_b);

  // Exponent wraps mod 16; a product in [2,4) shifts right by one.
  assign exp_sum = a.exp + b.exp + EXP_ADJ;
  assign exp_n   = exp_sum + FP8_EXP_W'(sig_p[PROD_W-1]);
  assign mant_n  = sig_p[PROD_W-1] ? sig_p[PROD_W-2 -: FP8_MANT_W]
                                   : sig_p[PROD_W-3 -: FP8_MANT_W];
  assign unused_lsbs = ^sig_p[PROD_W-SIG_W-2:0];

  always_comb begin
    product_c = {sign, exp_n, mant_n};
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      product_c = FP8_QNAN;
    end else if (a_inf || b_inf) begin
      product_c = {sign, FP8_INF_EXP, FP8_MANT_W'(0)};
    end else if (a_zero || b_zero) begin
      product_c = {sign, FP8_EXP_W'(0), FP8_MANT_W'(0)};
    end
  end

endmodule

// File: rtl/fp8_mul_arbiter.sv
// Round-robin arbiter feeding N_REQ requesters into one shared two-stage FP8
// multiplier pipeline with ready/valid backpressure on the response side.
module fp8_mul_arbiter
  import fp8_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*FP8_W-1:0] req_a,
  input  logic [N_REQ*FP8_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [FP8_W-1:0]       rsp_product,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy
);

  logic [N_REQ-1:0][FP8_W-1:0] a_arr, b_arr;

  logic              s1_valid_q, s1_valid_d;
  logic [FP8_W-1:0]  s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [ID_W-1:0]   s1_id_q, s1_id_d;
  logic              s2_valid_q, s2_valid_d;
  logic [FP8_W-1:0]  s2_prod_q, s2_prod_d;
  logic [ID_W-1:0]   s2_id_q, s2_id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic              s2_load, s1_load, accept;
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  int unsigned       cand;
  logic [FP8_W-1:0]  core_prod;

  assign a_arr = req_a;
  assign b_arr = req_b;

  assign s2_load = !s2_valid_q || rsp_ready;
  assign s1_load = !s1_valid_q || s2_load;

  // First valid requester at or after rr_ptr, wrapping past N_REQ-1.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!grant_found && req_valid[ID_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  assign accept    = grant_found && s1_load && !rst;
  assign req_ready = accept ? (N_REQ'(1) << grant_idx) : '0;

  fp8_mul_core u_core (
    .a_i       (s1_a_q),
    .b_i       (s1_b_q),
    .product_c (core_prod)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_prod_d  = s2_prod_q;
    s2_id_d    = s2_id_q;
    rr_ptr_d   = rr_ptr_q;
    // Data registers only move with a real entry so held outputs stay clean.
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_prod_d = core_prod;
        s2_id_d   = s1_id_q;
      end
    end
    if (s1_load) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_a_d  = a_arr[grant_idx];
        s1_b_d  = b_arr[grant_idx];
        s1_id_d = grant_idx;
      end
    end
    if (accept) begin
      rr_ptr_d = (32'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_prod_q  <= '0;
      s2_id_q    <= '0;
      rr_ptr_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_prod_q  <= s2_prod_d;
      s2_id_q    <= s2_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign rsp_valid   = s2_valid_q;
  assign rsp_product = s2_prod_q;
  assign rsp_id      = s2_id_q;
  assign busy        = s1_valid_q || s2_valid_q;

endmodule
